// File: rtl/delta_reg_bank.sv
// delta_reg_bank: multi-channel change tracker.
// Each channel keeps a reference copy of its input and raises a sticky flag,
// a saturating event counter and a sticky overflow bit when the input moves
// (any-bit change in mode 0, beyond a shared unsigned deadband in mode 1).
// Reading a channel clears its flag, counter and overflow; a change in the
// read cycle itself re-arms flag and counter so no event is lost.
// The enabled flags are OR-reduced into one registered interrupt.
module delta_reg_bank #(
    parameter int NUM_CHANNELS = 8,
    parameter int DATA_WIDTH   = 32,
    parameter int CNT_WIDTH    = 8,
    parameter int SEL_WIDTH    = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                               CLK,
    input  logic                               RST,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] VALUE_IN,
    input  logic [NUM_CHANNELS-1:0]            MODE,
    input  logic [DATA_WIDTH-1:0]              DEADBAND,
    input  logic [NUM_CHANNELS-1:0]            IRQ_EN,
    input  logic                               READ_EVENT,
    input  logic [SEL_WIDTH-1:0]               READ_SEL,
    output logic [NUM_CHANNELS*DATA_WIDTH-1:0] VALUE_OUT,
    output logic [NUM_CHANNELS-1:0]            CHANGE_FLAGS,
    output logic [NUM_CHANNELS-1:0]            OVERFLOW,
    output logic [CNT_WIDTH-1:0]               CHANGE_COUNT,
    output logic                               IRQ
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [CNT_WIDTH-1:0] w_cnt [NUM_CHANNELS];
    logic                 r_irq;

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
        logic [DATA_WIDTH-1:0] w_in;
        logic [DATA_WIDTH-1:0] w_diff;
        logic                  w_event;
        logic                  w_rd;
        logic [DATA_WIDTH-1:0] r_ref;
        logic [CNT_WIDTH-1:0]  r_cnt;
        logic                  r_flag;
        logic                  r_ovf;

        assign w_in    = VALUE_IN[g*DATA_WIDTH +: DATA_WIDTH];
        // Magnitude of the distance, computed without wrap-around.
        assign w_diff  = (w_in >= r_ref) ? (w_in - r_ref) : (r_ref - w_in);
        assign w_event = MODE[g] ? (w_diff > DEADBAND) : (w_in != r_ref);
        assign w_rd    = READ_EVENT && (READ_SEL == SEL_WIDTH'(g));

        // Per-channel reference, sticky flag, saturating counter and overflow.
        always_ff @(posedge CLK) begin
            if (RST) begin
                r_ref  <= '0;
                r_cnt  <= '0;
                r_flag <= 1'b0;
                r_ovf  <= 1'b0;
            end else begin
                // Mode 0 tracks every cycle; mode 1 only re-anchors on an event,
                // so slow drift inside the deadband is measured from the anchor.
                if (!MODE[g] || w_event) begin
                    r_ref <= w_in;
                end

                if (w_rd && w_event) begin
                    r_flag <= 1'b1;
                    r_cnt  <= CNT_WIDTH'(1);
                end else if (w_rd) begin
                    r_flag <= 1'b0;
                    r_cnt  <= '0;
                end else if (w_event) begin
                    r_flag <= 1'b1;
                    if (r_cnt != CNT_MAX) begin
                        r_cnt <= r_cnt + CNT_WIDTH'(1);
                    end
                end

                if (w_rd) begin
                    r_ovf <= 1'b0;
                end else if (w_event && (r_cnt == CNT_MAX)) begin
                    r_ovf <= 1'b1;
                end
            end
        end

        assign VALUE_OUT[g*DATA_WIDTH +: DATA_WIDTH] = r_ref;
        assign CHANGE_FLAGS[g] = r_flag;
        assign OVERFLOW[g]     = r_ovf;
        assign w_cnt[g]        = r_cnt;
    end

    // Count readback mux; shows the pre-clear value during the read cycle.
    always_comb begin
        CHANGE_COUNT = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (READ_SEL == SEL_WIDTH'(i)) begin
                CHANGE_COUNT = w_cnt[i];
            end
        end
    end

    // Registered interrupt from the enabled sticky flags.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= |(CHANGE_FLAGS & IRQ_EN);
        end
    end

    assign IRQ = r_irq;

endmodule
